// File: rtl/encoder_pkg.sv
// Shared types and constants for the registered 4-to-2 one-hot encoder.
// Optional priority-encoding mode is selected by ENCODER_4_2_PRIORITY_EN.
package encoder_pkg;

  localparam int unsigned REQ_W = 4;
  localparam int unsigned IDX_W = 2;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [REQ_W-1:0] req_t;

  // Bit order matches the d_out port: {invalid, index}.
  typedef struct packed {
    logic invalid;
    idx_t idx;
  } result_t;

  localparam idx_t INVALID_IDX = 2'b00;

  localparam result_t RESULT_RST = '{invalid: 1'b0, idx: 2'b00};
  localparam result_t RESULT_BAD = '{invalid: 1'b1, idx: INVALID_IDX};

  function automatic result_t make_result(input logic invalid, input idx_t idx);
    result_t r;
    r.invalid = invalid;
    r.idx     = invalid ? INVALID_IDX : idx;
    return r;
  endfunction

endpackage

// File: rtl/encoder_4_2_bh_onehot_check.sv
// Combinational one-hot validator/encoder: 4-bit request vector to {invalid, index}.
// With ENCODER_4_2_PRIORITY_EN defined, the highest set bit wins and only 0000 is invalid.
module onehot_check
  import encoder_pkg::*;
(
  input  req_t    vec_i,
  output result_t res_o
);

`ifdef ENCODER_4_2_PRIORITY_EN

  always_comb begin
    res_o = RESULT_BAD;
    // Ascending scan so the last hit, i.e. the highest set bit, is kept.
    for (int i = 0; i < REQ_W; i++) begin
      if (vec_i[i]) begin
        res_o = make_result(1'b0, idx_t'(i));
      end
    end
  end

`else

  always_comb begin
    res_o = RESULT_BAD;
    case (vec_i)
      4'b0001: res_o = make_result(1'b0, 2'd0);
      4'b0010: res_o = make_result(1'b0, 2'd1);
      4'b0100: res_o = make_result(1'b0, 2'd2);
      4'b1000: res_o = make_result(1'b0, 2'd3);
      default: res_o = RESULT_BAD;
    endcase
  end

`endif

endmodule

// File: rtl/encoder_4_2_bh.sv
// Registered 4-to-2 one-hot encoder with invalid flag and saturating invalid-sample counter.
// Encoding mode follows ENCODER_4_2_PRIORITY_EN (see onehot_check).
module encoder_4_2_bh
  import encoder_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [3:0]       d_in,
  input  logic             cnt_clr,
  output logic [2:0]       d_out,
  output logic             invalid_data,
  output logic             out_valid,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  result_t          chk_res;
  result_t          res_q, res_d;
  logic             vld_q, vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bad_accept;

  onehot_check u_onehot_check (
    .vec_i (d_in),
    .res_o (chk_res)
  );

  assign bad_accept = in_valid && chk_res.invalid;

  always_comb begin
    res_d = res_q;
    vld_d = in_valid;
    cnt_d = cnt_q;
    if (in_valid) begin
      res_d = chk_res;
    end
    // Clear takes priority over a simultaneous invalid acceptance.
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (bad_accept && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= RESULT_RST;
      vld_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      res_q <= res_d;
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

  assign d_out        = res_q;
  assign invalid_data = res_q.invalid;
  assign out_valid    = vld_q;
  assign err_cnt      = cnt_q;

endmodule

// File: tb/tb_encoder_4_2_bh.sv
// Self-checking bench for encoder_4_2_bh: directed plan steps plus random traffic
// against a behavioural model; honours ENCODER_4_2_PRIORITY_EN.
module tb_encoder_4_2_bh;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [3:0]       d_in;
  logic             cnt_clr;
  logic [2:0]       d_out;
  logic             invalid_data;
  logic             out_valid;
  logic [CNT_W-1:0] err_cnt;

  int tests_run;
  int tests_failed;

  // Model state
  logic [2:0] m_dout;
  logic       m_inv;
  logic       m_ovalid;
  int         m_cnt;

  encoder_4_2_bh #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .d_in         (d_in),
    .cnt_clr      (cnt_clr),
    .d_out        (d_out),
    .invalid_data (invalid_data),
    .out_valid    (out_valid),
    .err_cnt      (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic ref_encode(input logic [3:0] v, output logic inv, output logic [1:0] idx);
    inv = 1'b1;
    idx = 2'b00;
`ifdef ENCODER_4_2_PRIORITY_EN
    if (v != 4'b0000) begin
      inv = 1'b0;
      for (int i = 0; i < 4; i++) if (v[i]) idx = 2'(i);
    end
`else
    if ($countones(v) == 1) begin
      inv = 1'b0;
      for (int i = 0; i < 4; i++) if (v[i]) idx = 2'(i);
    end
`endif
  endtask

  task automatic model_reset();
    m_dout   = 3'b000;
    m_inv    = 1'b0;
    m_ovalid = 1'b0;
    m_cnt    = 0;
  endtask

  task automatic model_edge(input logic v, input logic [3:0] d, input logic clr);
    logic       inv;
    logic [1:0] idx;
    ref_encode(d, inv, idx);
    m_ovalid = v;
    if (v) begin
      m_inv  = inv;
      m_dout = {inv, idx};
    end
    if (clr) m_cnt = 0;
    else if (v && inv && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".d_out"},        8'(d_out),        8'(m_dout));
    check({tag, ".invalid_data"}, 8'(invalid_data), 8'(m_inv));
    check({tag, ".out_valid"},    8'(out_valid),    8'(m_ovalid));
    check({tag, ".err_cnt"},      8'(err_cnt),      8'(m_cnt));
  endtask

  // Drive inputs, take one edge, update model, check just after the edge.
  task automatic step(input string tag, input logic v, input logic [3:0] d, input logic clr);
    in_valid = v;
    d_in     = d;
    cnt_clr  = clr;
    @(posedge clk);
    model_edge(v, d, clr);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic       rv;
    logic [3:0] rd;
    logic       rc;
    logic [3:0] onehot_tab [4];

    tests_run    = 0;
    tests_failed = 0;
    onehot_tab[0] = 4'b0001;
    onehot_tab[1] = 4'b0010;
    onehot_tab[2] = 4'b0100;
    onehot_tab[3] = 4'b1000;

    // Reset held with busy inputs
    rst_n    = 1'b0;
    in_valid = 1'b1;
    d_in     = 4'b1111;
    cnt_clr  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step("first_accept", 1'b1, 4'b1111, 1'b0);

    // Walk one-hot
    for (int i = 0; i < 4; i++) step("walk", 1'b1, onehot_tab[i], 1'b0);

    // Invalid sweep
    step("clr_before_sweep", 1'b0, 4'b0000, 1'b1);
    step("inv_0000", 1'b1, 4'b0000, 1'b0);
    step("inv_0011", 1'b1, 4'b0011, 1'b0);
    step("inv_1111", 1'b1, 4'b1111, 1'b0);

    // Hold
    step("hold_load", 1'b1, 4'b0100, 1'b0);
    step("hold_idle", 1'b0, 4'b1000, 1'b0);
    step("hold_idle2", 1'b0, 4'b0001, 1'b0);

    // Saturation then clear beating a simultaneous invalid sample
    step("sat_clr", 1'b0, 4'b0000, 1'b1);
    for (int i = 0; i < 5; i++) step("sat", 1'b1, 4'b0000, 1'b0);
    step("clr_wins", 1'b1, 4'b0000, 1'b1);

    // Multi-bit codes (priority or invalid depending on build)
    step("multi_0110", 1'b1, 4'b0110, 1'b0);
    step("multi_0111", 1'b1, 4'b0111, 1'b0);
    step("multi_1010", 1'b1, 4'b1010, 1'b0);
    step("zero",       1'b1, 4'b0000, 1'b0);

    // Asynchronous reset mid-operation, between clock edges
    in_valid = 1'b1;
    d_in     = 4'b1000;
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_reset");
    @(posedge clk);
    #1;
    check_all("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    step("post_reset", 1'b1, 4'b1000, 1'b0);

    // Random traffic, biased towards one-hot codes
    for (int n = 0; n < 300; n++) begin
      rv = ($urandom_range(0, 3) != 0);
      rd = ($urandom_range(0, 1) == 0) ? onehot_tab[$urandom_range(0, 3)] : 4'($urandom);
      rc = ($urandom_range(0, 15) == 0);
      step("rand", rv, rd, rc);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
